// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between instruction and data masters
// Ports: clk/reset (sync, active-high); inst_* and data_* master request/response
//   ports; m_* shared downstream port. The arbiter returns responses in order to the
//   master that issued the request.
// Parameter OUTSTANDING: depth of the in-order response tracker (power of two, >=1).
// Macro SRAM_ARB_RR_EN: round-robin arbitration when defined, else data-over-inst priority.
module sram_port_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] DEPTH = CW'(OUTSTANDING);
    logic                   r_lock_v;
    logic                   r_lock_id;
    logic [OUTSTANDING-1:0] r_ids;
    logic [PW-1:0]          r_wp;
    logic [PW-1:0]          r_rp;
    logic [CW-1:0]          r_cnt;
    logic                   w_pol;
    logic                   w_sel;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head;
`ifdef SRAM_ARB_RR_EN
    logic                   r_rr;
    // r_rr names the master favoured when both request (0=inst, 1=data)
    assign w_pol = (inst_req & data_req) ? r_rr : data_req;
`else
    assign w_pol = data_req;
`endif
    // a presented-but-unaccepted request keeps its grant until accepted
    assign w_sel        = r_lock_v ? r_lock_id : w_pol;
    assign w_full       = r_cnt == DEPTH;
    assign w_empty      = r_cnt == '0;
    assign m_req        = (w_sel ? data_req : inst_req) & ~w_full & ~reset;
    assign m_wr         = w_sel ? data_wr    : inst_wr;
    assign m_size       = w_sel ? data_size  : inst_size;
    assign m_wstrb      = w_sel ? data_wstrb : inst_wstrb;
    assign m_addr       = w_sel ? data_addr  : inst_addr;
    assign m_wdata      = w_sel ? data_wdata : inst_wdata;
    assign w_push       = m_req & m_addr_ok;
    // responses with nothing outstanding are dropped
    assign w_pop        = m_data_ok & ~w_empty & ~reset;
    assign w_head       = r_ids[r_rp];
    assign inst_addr_ok = w_push & ~w_sel;
    assign data_addr_ok = w_push & w_sel;
    assign inst_data_ok = w_pop & ~w_head;
    assign data_data_ok = w_pop & w_head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_v  <= 1'b0;
            r_lock_id <= 1'b0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
`ifdef SRAM_ARB_RR_EN
            r_rr      <= 1'b0;
`endif
        end else begin
            if (m_req & ~m_addr_ok) begin
                r_lock_v  <= 1'b1;
                r_lock_id <= w_sel;
            end else if (w_push) begin
                r_lock_v  <= 1'b0;
            end
            if (w_push) begin
                r_ids[r_wp] <= w_sel;
                r_wp        <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
`ifdef SRAM_ARB_RR_EN
                r_rr        <= ~w_sel;
`endif
            end
            if (w_pop)
                r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [3:0]  inst_wstrb, data_wstrb, m_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          checks = 0;
    int          failures = 0;

    sram_port_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        // outputs held off during reset even with request and ready
        inst_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #2;
        chk("rst_m_req", m_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        tick();
        idle_inputs();
        reset = 0;

        // single read
        tick();
        inst_req = 1; inst_addr = 32'h1c000000; m_addr_ok = 1;
        #2;
        chk("rd_m_req", m_req, 1);
        chk("rd_m_addr", m_addr, 32'h1c000000);
        chk("rd_inst_addr_ok", inst_addr_ok, 1);
        chk("rd_data_addr_ok", data_addr_ok, 0);
        tick();
        inst_req = 0; m_addr_ok = 0;
        #2;
        chk("rd_c1_inst_data_ok", inst_data_ok, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h02800c0c;
        #2;
        chk("rd_inst_data_ok", inst_data_ok, 1);
        chk("rd_inst_rdata", inst_rdata, 32'h02800c0c);
        chk("rd_data_data_ok", data_data_ok, 0);
        do_reset();

        // contention with downstream always ready and answering every cycle
        inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000;
        m_addr_ok = 1; m_data_ok = 1;
        #2;
`ifdef SRAM_ARB_RR_EN
        chk("ct0_inst_addr_ok", inst_addr_ok, 1);
        chk("ct0_data_addr_ok", data_addr_ok, 0);
        tick(); #2;
        chk("ct1_data_addr_ok", data_addr_ok, 1);
        chk("ct1_inst_data_ok", inst_data_ok, 1);
        tick(); #2;
        chk("ct2_inst_addr_ok", inst_addr_ok, 1);
        chk("ct2_data_data_ok", data_data_ok, 1);
        tick(); #2;
        chk("ct3_data_addr_ok", data_addr_ok, 1);
        chk("ct3_inst_data_ok", inst_data_ok, 1);
`else
        chk("ct0_inst_addr_ok", inst_addr_ok, 0);
        chk("ct0_data_addr_ok", data_addr_ok, 1);
        tick(); #2;
        chk("ct1_inst_addr_ok", inst_addr_ok, 0);
        chk("ct1_data_addr_ok", data_addr_ok, 1);
        chk("ct1_data_data_ok", data_data_ok, 1);
        tick(); #2;
        chk("ct2_inst_addr_ok", inst_addr_ok, 0);
        chk("ct2_data_addr_ok", data_addr_ok, 1);
        tick(); #2;
        chk("ct3_inst_addr_ok", inst_addr_ok, 0);
        chk("ct3_data_addr_ok", data_addr_ok, 1);
`endif
        do_reset();

        // lock hold: inst presented, not accepted for 3 cycles; data arrives in cycle 1
        inst_req = 1; inst_addr = 32'h100;
        #2;
        chk("lk0_m_req", m_req, 1);
        chk("lk0_m_addr", m_addr, 32'h100);
        tick();
        data_req = 1; data_addr = 32'h200;
        #2;
        chk("lk1_m_addr", m_addr, 32'h100);
        chk("lk1_data_addr_ok", data_addr_ok, 0);
        tick(); #2;
        chk("lk2_m_addr", m_addr, 32'h100);
        tick();
        m_addr_ok = 1;
        #2;
        chk("lk3_m_addr", m_addr, 32'h100);
        chk("lk3_inst_addr_ok", inst_addr_ok, 1);
        chk("lk3_data_addr_ok", data_addr_ok, 0);
        tick();
        inst_req = 0;
        #2;
        chk("lk4_m_addr", m_addr, 32'h200);
        chk("lk4_data_addr_ok", data_addr_ok, 1);
        do_reset();

        // ordering: inst read then data write; responses route in order
        inst_req = 1; inst_addr = 32'h300; m_addr_ok = 1;
        #2;
        chk("or0_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
        data_addr = 32'h400; data_size = 2;
        #2;
        chk("or1_data_addr_ok", data_addr_ok, 1);
        chk("or1_m_wr", m_wr, 1);
        chk("or1_m_wstrb", m_wstrb, 4'hf);
        chk("or1_m_wdata", m_wdata, 32'hdeadbeef);
        tick();
        data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h55;
        #2;
        chk("or2_inst_data_ok", inst_data_ok, 1);
        chk("or2_data_data_ok", data_data_ok, 0);
        tick(); #2;
        chk("or3_inst_data_ok", inst_data_ok, 0);
        chk("or3_data_data_ok", data_data_ok, 1);
        do_reset();

        // full: two accepted, third blocked until a pop, offered the cycle after
        inst_req = 1; inst_addr = 32'h500; m_addr_ok = 1;
        #2;
        chk("fl0_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h504;
        #2;
        chk("fl1_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h508;
        #2;
        chk("fl2_m_req", m_req, 0);
        chk("fl2_inst_addr_ok", inst_addr_ok, 0);
        tick();
        m_data_ok = 1;
        #2;
        chk("fl3_m_req_pop", m_req, 0);
        chk("fl3_inst_data_ok", inst_data_ok, 1);
        tick();
        m_data_ok = 0;
        #2;
        chk("fl4_m_req", m_req, 1);
        chk("fl4_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; m_addr_ok = 0;

        // reset with 2 outstanding, then a spurious response
        reset = 1;
        tick();
        reset = 0; m_data_ok = 1;
        #2;
        chk("sp_inst_data_ok", inst_data_ok, 0);
        chk("sp_data_data_ok", data_data_ok, 0);
        tick();
        // an empty tracker must accept two more before going full
        m_data_ok = 0; inst_req = 1; inst_addr = 32'h600; m_addr_ok = 1;
        #2;
        chk("sp_acc0", inst_addr_ok, 1);
        tick(); #2;
        chk("sp_acc1", inst_addr_ok, 1);
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #2;
        chk("sp_resp", inst_data_ok, 1);
        tick();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
